lab_pixel_source: RTL and testbench
===================================

Name: lab_pixel_source

Overview:
Frame-scan pixel source that drives the LAB pixel stream consumed by Main_Top: L_data/A_data/B_data, pixel_clk strobe, Pixel_Col_cnt and Pixel_Row_cnt.
It raster-scans a frame, issues reads to a synchronous LAB frame memory, and aligns the returned data with the matching column/row counts.
It is the synthesizable producer side of the stream that Pixel_memory models behaviourally in simulation.

Parameters:
H_ACTIVE, 640, pixels per row (1..4095)
V_ACTIVE, 480, rows per frame (1..4095)
CLK_DIV, 1, clk50 cycles per pixel (1..15)
ADDR_W, 19, frame memory address width; must satisfy H_ACTIVE*V_ACTIVE <= 2^ADDR_W
CONTINUOUS, 0, 1 = restart the next frame automatically without a gap; 0 = stop after one frame

Ports:
clk50  in  1  system clock, 50 MHz; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  frame start request; sampled only in IDLE
busy  out  1  high while in RUN or DRAIN
frame_done  out  1  one-cycle pulse, coincident with the last pixel_clk of a frame
mem_rd_en  out  1  frame memory read strobe
mem_addr  out  ADDR_W  frame memory read address, row*H_ACTIVE+col
mem_L  in  32  L word; valid the cycle after mem_rd_en (1-cycle read latency)
mem_A  in  32  A word; same timing as mem_L
mem_B  in  32  B word; same timing as mem_L
pixel_clk  out  1  one-cycle pixel-valid strobe
Pixel_Col_cnt  out  12  column of the current pixel
Pixel_Row_cnt  out  12  row of the current pixel
L_data  out  32  L component; held between strobes
A_data  out  32  A component; held between strobes
B_data  out  32  B component; held between strobes

Behaviour:
- Reset (async, rst_n=0): every output goes to 0 and the state goes to IDLE. Internal counters and pipeline valid bits are cleared.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 -> RUN. The scan counters and address are set to 0.
  - RUN: issues one read per pixel period.
  - DRAIN: waits for the pipeline to empty, then -> IDLE.
- Pixel period: a divider counts 0..CLK_DIV-1. When the divider is 0 in RUN, the registered mem_rd_en=1 is driven with mem_addr equal to the issue address. mem_rd_en is 0 at all other times.
- Issue counters:
  - col increments after each issue.
  - When col=H_ACTIVE-1: col wraps to 0 and row increments.
  - When row=V_ACTIVE-1 and col=H_ACTIVE-1:
    - CONTINUOUS=0: RUN -> DRAIN.
    - CONTINUOUS=1: stay in RUN and wrap col, row and addr to 0 with no bubble.
  - The address is an incrementing counter; no multiplier.
- Pipeline stage 1: carries (valid, col, row) alongside the outstanding read.
- Pipeline stage 2: registers mem_L/A/B and col/row into the outputs, and pulses pixel_clk=1 for one cycle.
- Latency: start sampled at edge k -> mem_rd_en visible after edge k+1 -> pixel_clk visible after edge k+3. With CLK_DIV=1, pixel_clk is high on consecutive cycles.
- frame_done=1 in the same cycle as the pixel_clk for (H_ACTIVE-1, V_ACTIVE-1).
- DRAIN -> IDLE once stage 2 has emitted the last pixel. busy falls in the cycle after frame_done.
- start in RUN or DRAIN is ignored, including a start coincident with frame_done.
- Data outputs and counts hold their last values after the frame ends until the next pixel or reset.
- Reset mid-frame: the stream aborts immediately with no partial completion. After release, nothing happens until start, and the new frame begins at address 0.
- Widths: Pixel_Col_cnt and Pixel_Row_cnt are zero-extended to 12 bits. mem_addr wraps only through the explicit end-of-frame reset, never by overflow.

Decomposition:
- Shared package lab_stream_pkg:
  - LAB_W=32, CNT_W=12
  - default H_ACTIVE and V_ACTIVE
  - state encoding constants for IDLE, RUN, DRAIN
- Sub-module pixel_scan_counter: divider, col, row and address counters. It outputs an issue strobe plus col, row, addr, and an end-of-frame flag.

Test Plan:
1. Reset with no start (H=4, V=3, CLK_DIV=1) -> all outputs 0, no mem_rd_en and no pixel_clk for 20 cycles.
2. Single frame: H=4, V=3, CLK_DIV=1, memory model returns L=addr, A=addr+100, B=addr+200; pulse start -> 12 consecutive pixel_clk pulses, the first 3 cycles after the start edge.
   - Pixel n has col=n%4, row=n/4, L=n.
   - frame_done coincides with pixel 11 (col 3, row 2).
   - busy is low on the next cycle.
3. CLK_DIV=3 with the same frame -> mem_rd_en and pixel_clk each high 1 cycle in 3; 12 pixels span 34 cycles; data is held between strobes.
4. Extra start pulses asserted during RUN and on the frame_done cycle -> ignored. Exactly 12 pixels are emitted, then IDLE. A start issued after that begins a fresh frame at addr 0.
5. rst_n low for 2 cycles after pixel 5 -> outputs 0 asynchronously. After release, no pixel_clk until start; the next frame starts at col 0, row 0, L=0.
6. CONTINUOUS=1 -> address sequence 0..11,0..11 with no gap cycle; frame_done pulses every 12 pixel_clk; col/row wrap 3->0 and 2->0; busy stays 1.

Source files
------------

// File: rtl/lab_stream_pkg.sv
// Shared constants and FSM encoding for the LAB pixel stream producer.
package lab_stream_pkg;

    localparam int LAB_W        = 32;
    localparam int CNT_W        = 12;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster-scan issue counters: pixel-period divider, column, row and linear read address.
module pixel_scan_counter
    import lab_stream_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CLK_DIV  = 1,
    parameter int ADDR_W   = 19
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              run_i,
    output logic              issue_o,
    output logic [CNT_W-1:0]  col_o,
    output logic [CNT_W-1:0]  row_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              eof_o
);

    localparam int               DIV_W    = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_ACTIVE - 1);

    logic [DIV_W-1:0]  div_q,  div_d;
    logic [CNT_W-1:0]  col_q,  col_d;
    logic [CNT_W-1:0]  row_q,  row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign issue_o = run_i && (div_q == '0);
    assign eof_o   = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign col_o   = col_q;
    assign row_o   = row_q;
    assign addr_o  = addr_q;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
        div_d  = div_q;
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (!run_i) begin
            div_d  = '0;
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            if (issue_o) begin
                // The address is a plain counter; it only returns to 0 at end of frame.
                if (eof_o) begin
                    col_d  = '0;
                    row_d  = '0;
                    addr_d = '0;
                end else if (col_q == COL_LAST) begin
                    col_d  = '0;
                    row_d  = row_q + CNT_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    col_d  = col_q + CNT_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            div_q  <= '0;
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            div_q  <= div_d;
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/lab_pixel_source.sv
// Frame-scan LAB pixel source: issues frame-memory reads and aligns the returned
// L/A/B words with their column/row counts on a one-cycle pixel_clk strobe.
module lab_pixel_source
    import lab_stream_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int CLK_DIV    = 1,
    parameter int ADDR_W     = 19,
    parameter int CONTINUOUS = 0
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LAB_W-1:0]  mem_L,
    input  logic [LAB_W-1:0]  mem_A,
    input  logic [LAB_W-1:0]  mem_B,
    output logic              pixel_clk,
    output logic [CNT_W-1:0]  Pixel_Col_cnt,
    output logic [CNT_W-1:0]  Pixel_Row_cnt,
    output logic [LAB_W-1:0]  L_data,
    output logic [LAB_W-1:0]  A_data,
    output logic [LAB_W-1:0]  B_data
);

    localparam bit STOP_AT_EOF = (CONTINUOUS == 0);

    state_e state_q;

    logic              issue;
    logic              scan_eof;
    logic [CNT_W-1:0]  scan_col;
    logic [CNT_W-1:0]  scan_row;
    logic [ADDR_W-1:0] scan_addr;

    // Issue stage: the registered read request plus the position it belongs to.
    logic              rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  iss_col_q, iss_row_q;
    logic              iss_eof_q;

    // Stage 1: lines up with the memory's read data, one cycle after the strobe.
    logic              s1_valid_q;
    logic [CNT_W-1:0]  s1_col_q, s1_row_q;
    logic              s1_eof_q;

    // Stage 2: the visible pixel stream.
    logic              pix_q, fd_q;
    logic [CNT_W-1:0]  col_q, row_q;
    logic [LAB_W-1:0]  l_q, a_q, b_q;

    pixel_scan_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CLK_DIV  (CLK_DIV),
        .ADDR_W   (ADDR_W)
    ) u_scan (
        .clk50   (clk50),
        .rst_n   (rst_n),
        .run_i   (state_q == ST_RUN),
        .issue_o (issue),
        .col_o   (scan_col),
        .row_o   (scan_row),
        .addr_o  (scan_addr),
        .eof_o   (scan_eof)
    );

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            iss_col_q  <= '0;
            iss_row_q  <= '0;
            iss_eof_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_eof_q   <= 1'b0;
            pix_q      <= 1'b0;
            fd_q       <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            l_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (start) state_q <= ST_RUN;
                ST_RUN:   if (issue && scan_eof && STOP_AT_EOF) state_q <= ST_DRAIN;
                // The last pixel is on the output this cycle; nothing else is in flight.
                ST_DRAIN: if (fd_q) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase

            rd_q <= issue;
            if (issue) begin
                addr_q    <= scan_addr;
                iss_col_q <= scan_col;
                iss_row_q <= scan_row;
                iss_eof_q <= scan_eof;
            end

            s1_valid_q <= rd_q;
            s1_col_q   <= iss_col_q;
            s1_row_q   <= iss_row_q;
            s1_eof_q   <= iss_eof_q;

            pix_q <= s1_valid_q;
            fd_q  <= s1_valid_q && s1_eof_q;
            if (s1_valid_q) begin
                col_q <= s1_col_q;
                row_q <= s1_row_q;
                l_q   <= mem_L;
                a_q   <= mem_A;
                b_q   <= mem_B;
            end
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = fd_q;
    assign mem_rd_en     = rd_q;
    assign mem_addr      = addr_q;
    assign pixel_clk     = pix_q;
    assign Pixel_Col_cnt = col_q;
    assign Pixel_Row_cnt = row_q;
    assign L_data        = l_q;
    assign A_data        = a_q;
    assign B_data        = b_q;

endmodule

// File: tb/tb_lab_pixel_source.sv
// Directed bench for lab_pixel_source: three 4x3 instances (CLK_DIV=1, CLK_DIV=3, continuous)
// with synchronous memory models returning L=addr, A=addr+100, B=addr+200.
module tb_lab_pixel_source;

    typedef struct { int col; int row; int l; } vec_t;
    typedef struct { int cyc; int col; int row; int l; int a; int b; int fd; } pix_t;
    typedef struct { int cyc; int addr; } rd_t;

    logic clk50 = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #10 clk50 = ~clk50;
    always @(posedge clk50) cyc <= cyc + 1;

    logic        start_1 = 1'b0, start_3 = 1'b0, start_c = 1'b0;
    logic        busy_1, fd_1, rd_1, pclk_1;
    logic        busy_3, fd_3, rd_3, pclk_3;
    logic        busy_c, fd_c, rd_c, pclk_c;
    logic [3:0]  addr_1, addr_3, addr_c;
    logic [11:0] col_1, row_1, col_3, row_3, col_c, row_c;
    logic [31:0] l_1, a_1, b_1, l_3, a_3, b_3, l_c, a_c, b_c;
    logic [31:0] ml_1 = '0, ma_1 = '0, mb_1 = '0;
    logic [31:0] ml_3 = '0, ma_3 = '0, mb_3 = '0;
    logic [31:0] ml_c = '0, ma_c = '0, mb_c = '0;

    lab_pixel_source #(.H_ACTIVE(4), .V_ACTIVE(3), .CLK_DIV(1), .ADDR_W(4), .CONTINUOUS(0)) dut_1 (
        .clk50(clk50), .rst_n(rst_n), .start(start_1), .busy(busy_1), .frame_done(fd_1),
        .mem_rd_en(rd_1), .mem_addr(addr_1), .mem_L(ml_1), .mem_A(ma_1), .mem_B(mb_1),
        .pixel_clk(pclk_1), .Pixel_Col_cnt(col_1), .Pixel_Row_cnt(row_1),
        .L_data(l_1), .A_data(a_1), .B_data(b_1));

    lab_pixel_source #(.H_ACTIVE(4), .V_ACTIVE(3), .CLK_DIV(3), .ADDR_W(4), .CONTINUOUS(0)) dut_3 (
        .clk50(clk50), .rst_n(rst_n), .start(start_3), .busy(busy_3), .frame_done(fd_3),
        .mem_rd_en(rd_3), .mem_addr(addr_3), .mem_L(ml_3), .mem_A(ma_3), .mem_B(mb_3),
        .pixel_clk(pclk_3), .Pixel_Col_cnt(col_3), .Pixel_Row_cnt(row_3),
        .L_data(l_3), .A_data(a_3), .B_data(b_3));

    lab_pixel_source #(.H_ACTIVE(4), .V_ACTIVE(3), .CLK_DIV(1), .ADDR_W(4), .CONTINUOUS(1)) dut_c (
        .clk50(clk50), .rst_n(rst_n), .start(start_c), .busy(busy_c), .frame_done(fd_c),
        .mem_rd_en(rd_c), .mem_addr(addr_c), .mem_L(ml_c), .mem_A(ma_c), .mem_B(mb_c),
        .pixel_clk(pclk_c), .Pixel_Col_cnt(col_c), .Pixel_Row_cnt(row_c),
        .L_data(l_c), .A_data(a_c), .B_data(b_c));

    // Synchronous frame memories with one-cycle read latency.
    always @(posedge clk50) begin
        if (rd_1) begin
            ml_1 <= 32'(addr_1); ma_1 <= 32'(addr_1) + 32'd100; mb_1 <= 32'(addr_1) + 32'd200;
        end
        if (rd_3) begin
            ml_3 <= 32'(addr_3); ma_3 <= 32'(addr_3) + 32'd100; mb_3 <= 32'(addr_3) + 32'd200;
        end
        if (rd_c) begin
            ml_c <= 32'(addr_c); ma_c <= 32'(addr_c) + 32'd100; mb_c <= 32'(addr_c) + 32'd200;
        end
    end

    pix_t pq1[$], pq3[$], pqc[$], chk_q[$];
    rd_t  rq1[$], rq3[$], rqc[$], chk_r[$];
    int   busy_last_1 = -1, busy_last_3 = -1;

    // Stream monitor, sampling away from the active edge.
    always @(negedge clk50) begin
        if (pclk_1 === 1'b1) pq1.push_back('{cyc, int'(col_1), int'(row_1), int'(l_1), int'(a_1), int'(b_1), int'(fd_1)});
        if (pclk_3 === 1'b1) pq3.push_back('{cyc, int'(col_3), int'(row_3), int'(l_3), int'(a_3), int'(b_3), int'(fd_3)});
        if (pclk_c === 1'b1) pqc.push_back('{cyc, int'(col_c), int'(row_c), int'(l_c), int'(a_c), int'(b_c), int'(fd_c)});
        if (rd_1 === 1'b1) rq1.push_back('{cyc, int'(addr_1)});
        if (rd_3 === 1'b1) rq3.push_back('{cyc, int'(addr_3)});
        if (rd_c === 1'b1) rqc.push_back('{cyc, int'(addr_c)});
        if (busy_1 === 1'b1) busy_last_1 <= cyc;
        if (busy_3 === 1'b1) busy_last_3 <= cyc;
    end

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk50);
    endtask

    // Raise start for one cycle; k is the cycle count right after the sampling edge.
    task automatic pulse_start(input int which, output int k);
        @(negedge clk50);
        k = cyc + 1;
        case (which)
            1:       start_1 = 1'b1;
            3:       start_3 = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(negedge clk50);
        start_1 = 1'b0; start_3 = 1'b0; start_c = 1'b0;
    endtask

    task automatic check_pixels(input string tag, input int base, input int period, input int count, input bit exact);
        int idx;
        if (exact) check({tag, " pixel count"}, 64'(chk_q.size()), 64'(count));
        else       check({tag, " pixel count >= min"}, 64'(chk_q.size() >= count), 64'd1);
        for (int n = 0; n < count; n++) begin
            if (n >= chk_q.size()) break;
            idx = n % 12;
            check($sformatf("%s pix%0d col", tag, n), 64'(chk_q[n].col), 64'(tbl[idx].col));
            check($sformatf("%s pix%0d row", tag, n), 64'(chk_q[n].row), 64'(tbl[idx].row));
            check($sformatf("%s pix%0d L", tag, n), 64'(chk_q[n].l), 64'(tbl[idx].l));
            check($sformatf("%s pix%0d A", tag, n), 64'(chk_q[n].a), 64'(tbl[idx].l + 100));
            check($sformatf("%s pix%0d B", tag, n), 64'(chk_q[n].b), 64'(tbl[idx].l + 200));
            check($sformatf("%s pix%0d frame_done", tag, n), 64'(chk_q[n].fd), 64'(idx == 11));
            check($sformatf("%s pix%0d cycle", tag, n), 64'(chk_q[n].cyc), 64'(base + period * n));
        end
    endtask

    task automatic check_reads(input string tag, input int base, input int period, input int count, input bit exact);
        if (exact) check({tag, " read count"}, 64'(chk_r.size()), 64'(count));
        else       check({tag, " read count >= min"}, 64'(chk_r.size() >= count), 64'd1);
        for (int n = 0; n < count; n++) begin
            if (n >= chk_r.size()) break;
            check($sformatf("%s rd%0d addr", tag, n), 64'(chk_r[n].addr), 64'(n % 12));
            check($sformatf("%s rd%0d cycle", tag, n), 64'(chk_r[n].cyc), 64'(base + period * n));
        end
    endtask

    task automatic check_zero_1(input string tag);
        check({tag, " ctl outputs"}, 64'({busy_1, fd_1, rd_1, addr_1, pclk_1, col_1, row_1}), 64'd0);
        check({tag, " L_data"}, 64'(l_1), 64'd0);
        check({tag, " A_data"}, 64'(a_1), 64'd0);
        check({tag, " B_data"}, 64'(b_1), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;

        tbl[0]  = '{0, 0, 0};  tbl[1]  = '{1, 0, 1};  tbl[2]  = '{2, 0, 2};  tbl[3]  = '{3, 0, 3};
        tbl[4]  = '{0, 1, 4};  tbl[5]  = '{1, 1, 5};  tbl[6]  = '{2, 1, 6};  tbl[7]  = '{3, 1, 7};
        tbl[8]  = '{0, 2, 8};  tbl[9]  = '{1, 2, 9};  tbl[10] = '{2, 2, 10}; tbl[11] = '{3, 2, 11};

        #5 rst_n = 1'b0;
        #30 rst_n = 1'b1;

        // 1: reset state, then idle without start
        @(negedge clk50);
        check_zero_1("t1 reset");
        check("t1 reset dut3 ctl", 64'({busy_3, fd_3, rd_3, pclk_3, l_3}), 64'd0);
        check("t1 reset dutc ctl", 64'({busy_c, fd_c, rd_c, pclk_c, l_c}), 64'd0);
        repeat (20) @(negedge clk50);
        check("t1 no pixel_clk", 64'(pq1.size()), 64'd0);
        check("t1 no mem_rd_en", 64'(rq1.size()), 64'd0);
        check_zero_1("t1 idle");

        // 2: single frame, CLK_DIV=1
        pulse_start(1, k);
        wait_until(k + 30);
        chk_q = pq1; check_pixels("t2", k + 3, 1, 12, 1'b1);
        chk_r = rq1; check_reads("t2", k + 1, 1, 12, 1'b1);
        check("t2 busy last cycle", 64'(busy_last_1), 64'(k + 14));
        check("t2 busy after", 64'(busy_1), 64'd0);
        check("t2 held L", 64'(l_1), 64'd11);
        check("t2 held col/row", 64'({col_1, row_1}), 64'({12'd3, 12'd2}));
        check("t2 pixel_clk low", 64'(pclk_1), 64'd0);

        // 3: CLK_DIV=3
        pulse_start(3, k);
        wait_until(k + 7);
        check("t3 strobe low between", 64'(pclk_3), 64'd0);
        check("t3 held L", 64'(l_3), 64'd1);
        check("t3 held col", 64'(col_3), 64'd1);
        wait_until(k + 8);
        check("t3 held A", 64'(a_3), 64'd101);
        wait_until(k + 45);
        chk_q = pq3; check_pixels("t3", k + 3, 3, 12, 1'b1);
        chk_r = rq3; check_reads("t3", k + 1, 3, 12, 1'b1);
        if (pq3.size() == 12) check("t3 span", 64'(pq3[11].cyc - pq3[0].cyc + 1), 64'd34);
        check("t3 busy last cycle", 64'(busy_last_3), 64'(k + 36));

        // 4: stray starts during RUN and on the frame_done cycle
        pq1.delete(); rq1.delete();
        pulse_start(1, k);
        wait_until(k + 5);
        start_1 = 1'b1;
        @(negedge clk50);
        start_1 = 1'b0;
        wait_until(k + 14);
        check("t4 frame_done cycle", 64'({fd_1, pclk_1}), 64'b11);
        start_1 = 1'b1;
        @(negedge clk50);
        start_1 = 1'b0;
        wait_until(k + 40);
        check("t4 pixel count", 64'(pq1.size()), 64'd12);
        check("t4 read count", 64'(rq1.size()), 64'd12);
        check("t4 idle after", 64'(busy_1), 64'd0);
        pq1.delete(); rq1.delete();
        pulse_start(1, k2);
        wait_until(k2 + 20);
        chk_q = pq1; check_pixels("t4 restart", k2 + 3, 1, 12, 1'b1);
        chk_r = rq1; check_reads("t4 restart", k2 + 1, 1, 12, 1'b1);

        // 5: reset mid-frame
        pq1.delete(); rq1.delete();
        pulse_start(1, k);
        wait_until(k + 8);
        check("t5 pixel5 col/row", 64'({pclk_1, col_1, row_1}), 64'({1'b1, 12'd1, 12'd1}));
        @(negedge clk50);
        #2 rst_n = 1'b0;
        #1 check_zero_1("t5 async reset");
        @(negedge clk50);
        @(negedge clk50);
        #2 rst_n = 1'b1;
        pq1.delete(); rq1.delete();
        repeat (20) @(negedge clk50);
        check("t5 no pixel after reset", 64'(pq1.size()), 64'd0);
        check("t5 no read after reset", 64'(rq1.size()), 64'd0);
        check("t5 busy after reset", 64'(busy_1), 64'd0);
        pulse_start(1, k);
        wait_until(k + 20);
        chk_q = pq1; check_pixels("t5 new frame", k + 3, 1, 12, 1'b1);
        chk_r = rq1; check_reads("t5 new frame", k + 1, 1, 12, 1'b1);

        // 6: continuous frames
        pqc.delete(); rqc.delete();
        pulse_start(2, k);
        wait_until(k + 40);
        chk_q = pqc; check_pixels("t6", k + 3, 1, 24, 1'b0);
        chk_r = rqc; check_reads("t6", k + 1, 1, 24, 1'b0);
        check("t6 busy stays high", 64'(busy_c), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
